// File: rtl/instr_enc_pkg.sv
// Shared types and opcode constants for the RV32I instruction encoder.
package instr_enc_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        KIND_R      = 3'd0,
        KIND_LOAD   = 3'd1,
        KIND_ALUI   = 3'd2,
        KIND_STORE  = 3'd3,
        KIND_BRANCH = 3'd4
    } enc_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2,
        ST_ERR  = 2'd3
    } enc_state_e;

    typedef struct packed {
        enc_kind_e   kind;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
    } enc_req_t;

endpackage

// File: rtl/instr_enc_fmt.sv
// Combinational packing of one request into an RV32I word plus a legality flag.
// Legality checks are compiled in only when INSTR_ENC_CHECK_EN is defined.
module instr_enc_fmt
    import instr_enc_pkg::*;
(
    input  enc_req_t           req,
    output logic [WORD_W-1:0]  word_c,
    output logic               legal_c
);

    always_comb begin
        word_c  = '0;
        legal_c = 1'b1;
        case (req.kind)
            KIND_LOAD:   word_c = {req.imm[11:0], req.rs1, req.funct3, req.rd, OP_LOAD};
            KIND_ALUI:   word_c = {req.imm[11:0], req.rs1, req.funct3, req.rd, OP_ALUI};
            KIND_STORE:  word_c = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], OP_STORE};
            KIND_BRANCH: word_c = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                                   req.imm[4:1], req.imm[11], OP_BRANCH};
            default:     word_c = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, OP_R};
        endcase
`ifdef INSTR_ENC_CHECK_EN
        // 12-bit immediates must sign-extend cleanly; branch offsets must be even.
        case (req.kind)
            KIND_R:                           legal_c = 1'b1;
            KIND_LOAD, KIND_ALUI, KIND_STORE: legal_c = (req.imm[12] == req.imm[11]);
            KIND_BRANCH:                      legal_c = !req.imm[0];
            default:                          legal_c = 1'b0;
        endcase
`endif
    end

endmodule

// File: rtl/instr_encoder.sv
// Request stream -> RV32I words written sequentially into imem (two-stage pipeline).
// Define INSTR_ENC_CHECK_EN to reject illegal requests and raise the sticky err flag.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [12:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CAP = CNT_W'(1) << ADDR_W;

    enc_state_e        state_q, state_d;
    logic              s1_valid_q, s1_valid_d;
    enc_req_t          s1_req_q, s1_req_d;
    logic [CNT_W-1:0]  alloc_q, alloc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    logic [WORD_W-1:0] fmt_word;
    logic              fmt_legal;
    logic              s1_bad;
    logic              accept;

    instr_enc_fmt u_fmt (
        .req     (s1_req_q),
        .word_c  (fmt_word),
        .legal_c (fmt_legal)
    );

    // alloc tracks words written plus in flight, so capacity is never oversubscribed.
    assign s1_bad    = s1_valid_q && !fmt_legal;
    assign req_ready = (state_q == ST_RUN) && !start && (alloc_q < CAP) && !s1_bad;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        s1_valid_d = accept;
        s1_req_d   = s1_req_q;
        alloc_d    = alloc_q + CNT_W'(accept);
        count_d    = count_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        full_d     = full_q;
        err_d      = err_q;

        if (accept) begin
            s1_req_d = '{kind: enc_kind_e'(req_kind), funct3: req_funct3, funct7: req_funct7,
                         rd: req_rd, rs1: req_rs1, rs2: req_rs2, imm: req_imm};
        end

        if (s1_valid_q && fmt_legal) begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'(BASE_ADDR) + count_q[ADDR_W-1:0];
            wdata_d = fmt_word;
            count_d = count_q + CNT_W'(1);
            if (count_q + CNT_W'(1) == CAP) begin
                full_d = 1'b1;
            end
        end
`ifdef INSTR_ENC_CHECK_EN
        if (s1_bad) begin
            err_d = 1'b1;
        end
`endif

        case (state_q)
            ST_RUN: begin
                if (s1_bad) begin
                    state_d = ST_ERR;
                end else if (alloc_d == CAP) begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = state_q;
        endcase

        // start flushes the pipeline and rewinds the write pointer.
        if (start) begin
            state_d    = ST_RUN;
            s1_valid_d = 1'b0;
            we_d       = 1'b0;
            alloc_d    = '0;
            count_d    = '0;
            full_d     = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            alloc_q    <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_req_q   <= s1_req_d;
            alloc_q    <= alloc_d;
            count_q    <= count_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            full_q     <= full_d;
            err_q      <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = full_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with ADDR_W=2 (capacity 4 words).
module tb_instr_encoder;

    localparam int unsigned ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_kind = '0;
    logic [2:0]        req_funct3 = '0;
    logic [6:0]        req_funct7 = '0;
    logic [4:0]        req_rd = '0;
    logic [4:0]        req_rs1 = '0;
    logic [4:0]        req_rs2 = '0;
    logic [12:0]       req_imm = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    int total = 0;
    int bad   = 0;

    logic [31:0] wq_data[$];
    logic [31:0] wq_addr[$];

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Record every imem write, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            wq_data.push_back(imem_wdata);
            wq_addr.push_back(32'(imem_addr));
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive(input logic [2:0] kind, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [12:0] imm);
        req_valid  = 1'b1;
        req_kind   = kind;
        req_funct3 = f3;
        req_funct7 = f7;
        req_rd     = rd;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_imm    = imm;
    endtask

    task automatic send_one(input string tag, input logic [2:0] kind, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [12:0] imm,
                            input logic [31:0] exp_word, input logic [31:0] exp_addr,
                            input logic [31:0] exp_cnt);
        @(negedge clk);
        drive(kind, f3, f7, rd, rs1, rs2, imm);
        #1 check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check_eq({tag, "_we_early"}, 32'(imem_we), 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_we"}, 32'(imem_we), 32'd1);
        check_eq({tag, "_addr"}, 32'(imem_addr), exp_addr);
        check_eq({tag, "_wdata"}, imem_wdata, exp_word);
        check_eq({tag, "_count"}, 32'(count), exp_cnt);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_we", 32'(imem_we), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'd0);
        check_eq("rst_wdata", imem_wdata, 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("idle_ready", 32'(req_ready), 32'd0);

        // Four encodings fill the 4-word memory
        do_start();
        #1 check_eq("run_ready", 32'(req_ready), 32'd1);
        send_one("r_add", 3'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 32'd0, 32'd1);
        send_one("load", 3'd1, 3'd2, 7'd0, 5'd5, 5'd2, 5'd0, 13'h1FFC, 32'hFFC12283, 32'd1, 32'd2);
        send_one("store", 3'd3, 3'd2, 7'd0, 5'd0, 5'd2, 5'd6, 13'd8, 32'h00612423, 32'd2, 32'd3);
        send_one("branch", 3'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'h1FF8, 32'hFE208CE3, 32'd3, 32'd4);
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_ready", 32'(req_ready), 32'd0);

        // start clears full and count
        do_start();
        #1;
        check_eq("restart_full", 32'(full), 32'd0);
        check_eq("restart_count", 32'(count), 32'd0);
        check_eq("restart_ready", 32'(req_ready), 32'd1);
        send_one("alui", 3'd2, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 13'h1FFF, 32'hFFF10093, 32'd0, 32'd1);

        // Back-to-back stream of five R-type requests
        do_start();
        wq_data.delete();
        wq_addr.delete();
        for (int i = 0; i < 5; i++) begin
            drive(3'd0, 3'd0, 7'd0, 5'(i + 1), 5'd1, 5'd2, 13'd0);
            #1 check_eq("b2b_ready", 32'(req_ready), (i < 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("b2b_nwrites", 32'(wq_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < wq_data.size(); i++) begin
            check_eq("b2b_addr", wq_addr[i], 32'(i));
            check_eq("b2b_wdata", wq_data[i], 32'h00208033 | (32'(i + 1) << 7));
        end
        check_eq("b2b_full", 32'(full), 32'd1);
        check_eq("b2b_count", 32'(count), 32'd4);

        // start while a request is in flight and another is offered
        do_start();
        wq_data.delete();
        wq_addr.delete();
        drive(3'd0, 3'd0, 7'd0, 5'd7, 5'd1, 5'd2, 13'd0);
        @(negedge clk);
        start = 1'b1;
        drive(3'd0, 3'd0, 7'd0, 5'd8, 5'd1, 5'd2, 13'd0);
        #1 check_eq("start_prio_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("flush_nwrites", 32'(wq_data.size()), 32'd0);
        check_eq("flush_count", 32'(count), 32'd0);
        check_eq("flush_full", 32'(full), 32'd0);
        check_eq("flush_ready", 32'(req_ready), 32'd1);

`ifdef INSTR_ENC_CHECK_EN
        // Out-of-range ALUI immediate is consumed and flagged
        do_start();
        wq_data.delete();
        wq_addr.delete();
        @(negedge clk);
        drive(3'd2, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd2048);
        #1 check_eq("chk_accept_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 check_eq("chk_inflight_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_eq("chk_err", 32'(err), 32'd1);
        check_eq("chk_err_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("chk_nwrites", 32'(wq_data.size()), 32'd0);
        check_eq("chk_count", 32'(count), 32'd0);
        do_start();
        #1;
        check_eq("chk_clr_err", 32'(err), 32'd0);
        check_eq("chk_clr_ready", 32'(req_ready), 32'd1);
`else
        // Without checks, illegal kind encodes as R-type and immediates truncate
        do_start();
        send_one("kind5", 3'd5, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3, 32'd0, 32'd1);
        send_one("alui_trunc", 3'd2, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 13'd2048, 32'h80000013, 32'd1, 32'd2);
        check_eq("nochk_err", 32'(err), 32'd0);
        check_eq("nochk_ready", 32'(req_ready), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
